wash_phase_timer: RTL and testbench

WASH_PHASE_TIMER -- requirements
Module: wash_phase_timer

---
 rtl/wash_pkg.sv | 40 ++++
 rtl/wash_tach_watchdog.sv | 51 +++++
 rtl/wash_phase_timer.sv | 145 ++++++++++++++
 tb/tb_wash_phase_timer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/wash_pkg.sv
// Shared definitions for the wash controller and its phase timer: state codes,
// timer FSM encoding, default phase durations and state decode helpers.
package wash_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_READY = 4'd1,
        ST_SOAK  = 4'd2,
        ST_WASH  = 4'd3,
        ST_RINSE = 4'd4,
        ST_SPIN  = 4'd5,
        ST_DONE  = 4'd6
    } wash_state_e;

    typedef enum logic [1:0] {
        T_WAIT,
        T_TIMING,
        T_EXPIRED
    } timer_fsm_e;

    localparam int SOAK_CYC_DEF  = 20;
    localparam int WASH_CYC_DEF  = 40;
    localparam int RINSE_CYC_DEF = 30;
    localparam int SPIN_CYC_DEF  = 50;

    // Codes above DONE are not legal controller states and fall back to IDLE.
    function automatic wash_state_e decode_state(input logic [3:0] code);
        if (code <= 4'd6) return wash_state_e'(code);
        return ST_IDLE;
    endfunction

    function automatic logic is_timed(input wash_state_e s);
        return s inside {ST_SOAK, ST_WASH, ST_RINSE, ST_SPIN};
    endfunction

    function automatic logic is_motor_phase(input wash_state_e s);
        return s inside {ST_WASH, ST_RINSE, ST_SPIN};
    endfunction

endpackage

// File: rtl/wash_tach_watchdog.sv
// Motor stall watchdog: counts cycles since the last tach pulse while the motor
// should be turning, and latches a sticky failure flag when the limit is reached.
module wash_tach_watchdog
    import wash_pkg::*;
#(
    parameter int TACH_TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic active,
    input  logic restart,
    input  logic clear,
    input  logic run,
    input  logic tach,
    output logic failure
);

    localparam int CW = $clog2(TACH_TIMEOUT) + 1;
    localparam logic [CW-1:0] LIMIT = CW'(TACH_TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          fail_q, fail_d;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cnt_d  = cnt_q;
        fail_d = fail_q;
        if (clear) fail_d = 1'b0;
        // A tach pulse on the limit cycle wins over the failure.
        if (!active || restart || tach) begin
            cnt_d = '0;
        end else if (run && cnt_q < LIMIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LIMIT - 1'b1) fail_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            fail_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            fail_q <= fail_d;
        end
    end

    assign failure = fail_q;

endmodule

// File: rtl/wash_phase_timer.sv
// Phase timer for the wash controller: phase countdown, motor stall watchdog and
// spin imbalance detector. Define WASH_TIMER_PAUSE_EN to add the pause input.
module wash_phase_timer
    import wash_pkg::*;
#(
    parameter int SOAK_CYC     = SOAK_CYC_DEF,
    parameter int WASH_CYC     = WASH_CYC_DEF,
    parameter int RINSE_CYC    = RINSE_CYC_DEF,
    parameter int SPIN_CYC     = SPIN_CYC_DEF,
    parameter int TACH_TIMEOUT = 16,
    parameter int OOB_WINDOW   = 32,
    parameter int OOB_LIMIT    = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [3:0]  state,
    input  logic        motor_tach,
    input  logic        vib_pulse,
`ifdef WASH_TIMER_PAUSE_EN
    input  logic        pause,
`endif
    output logic        sig_Time_Out,
    output logic        sig_Out_Of_Balance,
    output logic        sig_Motor_Failure,
    output logic [15:0] remaining
);

    localparam int WW = $clog2(OOB_WINDOW) + 1;
    localparam int VW = $clog2(OOB_LIMIT) + 1;
    localparam logic [WW-1:0] WIN_LAST = WW'(OOB_WINDOW - 1);
    localparam logic [VW-1:0] VIB_LIM  = VW'(OOB_LIMIT);

    wash_state_e cur_ph, ph_q;
    timer_fsm_e  fsm_q, fsm_d;
    logic [15:0] rem_q, rem_d, dur;
    logic        to_q, to_d;
    logic [WW-1:0] win_q, win_d;
    logic [VW-1:0] vcnt_q, vcnt_d, vib_next;
    logic        hit_q, hit_d, oob_q, oob_d;
    logic        phase_change, run;

`ifdef WASH_TIMER_PAUSE_EN
    assign run = ~pause;
`else
    assign run = 1'b1;
`endif

    assign cur_ph       = decode_state(state);
    assign phase_change = (cur_ph != ph_q);

    always_comb begin
        case (cur_ph)
            ST_SOAK:  dur = 16'(SOAK_CYC - 1);
            ST_WASH:  dur = 16'(WASH_CYC - 1);
            ST_RINSE: dur = 16'(RINSE_CYC - 1);
            ST_SPIN:  dur = 16'(SPIN_CYC - 1);
            default:  dur = '0;
        endcase
    end

    // Phase countdown; a phase change always abandons the current count silently.
    always_comb begin
        fsm_d = fsm_q;
        rem_d = rem_q;
        to_d  = 1'b0;
        if (phase_change) begin
            fsm_d = is_timed(cur_ph) ? T_TIMING : T_WAIT;
            rem_d = dur;
        end else if (fsm_q == T_TIMING && run) begin
            if (rem_q == '0) begin
                to_d  = 1'b1;
                fsm_d = T_EXPIRED;
            end else begin
                rem_d = rem_q - 1'b1;
            end
        end
    end

    // Imbalance detector; the hit flag delays the sticky flag by one cycle.
    assign vib_next = (vib_pulse && vcnt_q < VIB_LIM) ? vcnt_q + 1'b1 : vcnt_q;

    always_comb begin
        win_d  = win_q;
        vcnt_d = vcnt_q;
        hit_d  = 1'b0;
        oob_d  = oob_q;
        if (cur_ph != ST_SPIN || phase_change) begin
            win_d  = '0;
            vcnt_d = '0;
            oob_d  = 1'b0;
        end else begin
            oob_d = oob_q | hit_q;
            if (run) begin
                hit_d = (vib_next >= VIB_LIM);
                if (win_q == WIN_LAST) begin
                    win_d  = '0;
                    vcnt_d = '0;
                end else begin
                    win_d  = win_q + 1'b1;
                    vcnt_d = vib_next;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ph_q   <= ST_IDLE;
            fsm_q  <= T_WAIT;
            rem_q  <= '0;
            to_q   <= 1'b0;
            win_q  <= '0;
            vcnt_q <= '0;
            hit_q  <= 1'b0;
            oob_q  <= 1'b0;
        end else begin
            ph_q   <= cur_ph;
            fsm_q  <= fsm_d;
            rem_q  <= rem_d;
            to_q   <= to_d;
            win_q  <= win_d;
            vcnt_q <= vcnt_d;
            hit_q  <= hit_d;
            oob_q  <= oob_d;
        end
    end

    wash_tach_watchdog #(
        .TACH_TIMEOUT (TACH_TIMEOUT)
    ) u_tach_wd (
        .clock   (clock),
        .reset_n (reset_n),
        .active  (is_motor_phase(cur_ph)),
        .restart (phase_change),
        .clear   (cur_ph == ST_IDLE),
        .run     (run),
        .tach    (motor_tach),
        .failure (sig_Motor_Failure)
    );

    assign sig_Time_Out       = to_q;
    assign sig_Out_Of_Balance = oob_q;
    assign remaining          = rem_q;

endmodule

// File: tb/tb_wash_phase_timer.sv
// Directed bench for wash_phase_timer with default parameters; the pause
// scenario is included when WASH_TIMER_PAUSE_EN is defined.
module tb_wash_phase_timer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [3:0]  state;
    logic        motor_tach;
    logic        vib_pulse;
`ifdef WASH_TIMER_PAUSE_EN
    logic        pause;
`endif
    logic        sig_Time_Out;
    logic        sig_Out_Of_Balance;
    logic        sig_Motor_Failure;
    logic [15:0] remaining;

    int n_tests = 0;
    int n_fail  = 0;

    wash_phase_timer dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .state              (state),
        .motor_tach         (motor_tach),
        .vib_pulse          (vib_pulse),
`ifdef WASH_TIMER_PAUSE_EN
        .pause              (pause),
`endif
        .sig_Time_Out       (sig_Time_Out),
        .sig_Out_Of_Balance (sig_Out_Of_Balance),
        .sig_Motor_Failure  (sig_Motor_Failure),
        .remaining          (remaining)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n    = 1'b0;
        state      = 4'd0;
        motor_tach = 1'b0;
        vib_pulse  = 1'b0;
`ifdef WASH_TIMER_PAUSE_EN
        pause      = 1'b0;
`endif
        #23;
        check("rst_rem", 32'(remaining), 0);
        check("rst_to", 32'(sig_Time_Out), 0);
        check("rst_oob", 32'(sig_Out_Of_Balance), 0);
        check("rst_mf", 32'(sig_Motor_Failure), 0);
        reset_n = 1'b1;
        step();
        step();
        check("idle_rem", 32'(remaining), 0);

        // SOAK with no tach: pulse exactly 20 edges after entry.
        state = 4'd2;
        step();
        check("soak_load", 32'(remaining), 19);
        for (int i = 1; i <= 19; i++) begin
            step();
            check("soak_rem", 32'(remaining), 32'(19 - i));
            check("soak_no_to", 32'(sig_Time_Out), 0);
        end
        step();
        check("soak_to", 32'(sig_Time_Out), 1);
        check("soak_mf", 32'(sig_Motor_Failure), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("expired_hold", 32'(sig_Time_Out), 0);
        end

        // WASH: tach exactly on the limit cycle clears, periodic tach keeps healthy.
        state = 4'd0;
        step();
        state = 4'd3;
        step();
        for (int i = 1; i <= 15; i++) begin
            step();
            check("tach_pre_limit", 32'(sig_Motor_Failure), 0);
        end
        motor_tach = 1'b1;
        step();
        motor_tach = 1'b0;
        check("tach_at_limit", 32'(sig_Motor_Failure), 0);
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 10; i++) begin
                motor_tach = (i == 9);
                step();
                check("tach_periodic", 32'(sig_Motor_Failure), 0);
            end
        end
        motor_tach = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            step();
            check("stall_pre", 32'(sig_Motor_Failure), 0);
        end
        step();
        check("stall_16", 32'(sig_Motor_Failure), 1);
        state = 4'd4;
        step();
        check("stall_sticky", 32'(sig_Motor_Failure), 1);
        state = 4'd0;
        step();
        check("stall_clear_idle", 32'(sig_Motor_Failure), 0);

        // WASH -> RINSE at remaining=5: reload to 29 with no pulse.
        state = 4'd3;
        step();
        check("wash_load", 32'(remaining), 39);
        for (int i = 1; i <= 34; i++) begin
            step();
            check("wash_rem", 32'(remaining), 32'(39 - i));
        end
        state = 4'd4;
        step();
        check("rinse_reload", 32'(remaining), 29);
        check("rinse_no_to", 32'(sig_Time_Out), 0);
        step();
        check("rinse_dec", 32'(remaining), 28);
        state = 4'd0;
        step();
        check("idle_wait_rem", 32'(remaining), 0);

        // SPIN: 3 pulses per window stay low, 4 in a window flag the next cycle.
        state = 4'd5;
        step();
        for (int i = 1; i <= 100; i++) begin
            vib_pulse  = (i == 5 || i == 15 || i == 25 || i == 34 || i == 50 || i == 64 ||
                          i == 70 || i == 75 || i == 80 || i == 85);
            motor_tach = (i % 8 == 0);
            step();
            check("oob", 32'(sig_Out_Of_Balance), (i >= 86) ? 32'd1 : 32'd0);
        end
        vib_pulse  = 1'b0;
        motor_tach = 1'b0;
        state = 4'd6;
        step();
        check("oob_leave_spin", 32'(sig_Out_Of_Balance), 0);
        state = 4'd0;
        step();

        // Asynchronous reset mid-TIMING with a stall flag raised.
        state = 4'd3;
        step();
        for (int i = 1; i <= 20; i++) step();
        check("pre_rst_mf", 32'(sig_Motor_Failure), 1);
        check("pre_rst_rem", 32'(remaining), 19);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_rem", 32'(remaining), 0);
        check("async_mf", 32'(sig_Motor_Failure), 0);
        check("async_to", 32'(sig_Time_Out), 0);
        check("async_oob", 32'(sig_Out_Of_Balance), 0);
        @(posedge clock);
        @(posedge clock);
        #2;
        reset_n = 1'b1;
        step();
        check("release_entry", 32'(remaining), 39);
        state = 4'd0;
        step();

`ifdef WASH_TIMER_PAUSE_EN
        // Pause 10 cycles during SOAK: pulse lands 30 edges after entry.
        state = 4'd2;
        step();
        for (int i = 1; i <= 4; i++) step();
        check("pause_pre", 32'(remaining), 15);
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("pause_hold", 32'(remaining), 15);
        end
        pause = 1'b0;
        for (int j = 15; j <= 30; j++) begin
            step();
            check("pause_to", 32'(sig_Time_Out), (j == 30) ? 32'd1 : 32'd0);
        end
        state = 4'd0;
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
